// File: rtl/trap_sequencer.sv
// M-mode trap sequencer: owns the trap CSRs, sequences trap entry and MRET return,
// and issues a one-cycle PC redirect to fetch while holding the pipeline with o_busy.
module trap_sequencer #(
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
   parameter bit          VECTORED_EN = 1'b1
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_trap_req,
   input  logic [4:0]  i_trap_cause,
   input  logic [31:0] i_trap_tval,
   input  logic [31:0] i_pc,
   input  logic        i_mret,
   input  logic        i_csr_we,
   input  logic [11:0] i_csr_addr,
   input  logic [31:0] i_csr_wdata,
   output logic [31:0] o_csr_rdata,
   output logic        o_csr_hit,
   output logic        o_busy,
   output logic        o_redirect,
   output logic [31:0] o_redirect_pc,
   output logic        o_mie
);

   localparam logic [11:0] AddrMstatus  = 12'h300;
   localparam logic [11:0] AddrMtvec    = 12'h305;
   localparam logic [11:0] AddrMscratch = 12'h340;
   localparam logic [11:0] AddrMepc     = 12'h341;
   localparam logic [11:0] AddrMcause   = 12'h342;
   localparam logic [11:0] AddrMtval    = 12'h343;

   typedef enum logic [1:0] {StIdle, StTrapRedir, StRetRedir} state_e;

   state_e      state_q, state_d;
   logic        mie_q, mie_d;
   logic        mpie_q, mpie_d;
   logic [31:2] mtvec_base_q, mtvec_base_d;
   logic        mtvec_mode_q, mtvec_mode_d;
   logic [31:0] mscratch_q, mscratch_d;
   logic [31:2] mepc_q, mepc_d;
   logic [31:0] mcause_q, mcause_d;
   logic [31:0] mtval_q, mtval_d;

   // mepc is word aligned, so the low PC bits never reach a register.
   logic unused_pc;
   assign unused_pc = ^i_pc[1:0];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= StIdle;
         mie_q        <= 1'b0;
         mpie_q       <= 1'b0;
         mtvec_base_q <= MTVEC_RESET[31:2];
         mtvec_mode_q <= MTVEC_RESET[0] & VECTORED_EN;
         mscratch_q   <= 32'h0;
         mepc_q       <= 30'h0;
         mcause_q     <= 32'h0;
         mtval_q      <= 32'h0;
      end else begin
         state_q      <= state_d;
         mie_q        <= mie_d;
         mpie_q       <= mpie_d;
         mtvec_base_q <= mtvec_base_d;
         mtvec_mode_q <= mtvec_mode_d;
         mscratch_q   <= mscratch_d;
         mepc_q       <= mepc_d;
         mcause_q     <= mcause_d;
         mtval_q      <= mtval_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      mie_d         = mie_q;
      mpie_d        = mpie_q;
      mtvec_base_d  = mtvec_base_q;
      mtvec_mode_d  = mtvec_mode_q;
      mscratch_d    = mscratch_q;
      mepc_d        = mepc_q;
      mcause_d      = mcause_q;
      mtval_d       = mtval_q;
      o_redirect    = 1'b0;
      o_redirect_pc = 32'h0;

      case (state_q)
         StIdle: begin
            if (i_trap_req) begin
               // The faulting instruction does not retire: any CSR write and MRET are dropped.
               mepc_d   = i_pc[31:2];
               mcause_d = {27'b0, i_trap_cause};
               mtval_d  = i_trap_tval;
               mpie_d   = mie_q;
               mie_d    = 1'b0;
               state_d  = StTrapRedir;
            end else begin
               if (i_csr_we) begin
                  case (i_csr_addr)
                     AddrMstatus: begin
                        if (!i_mret) begin
                           mie_d  = i_csr_wdata[3];
                           mpie_d = i_csr_wdata[7];
                        end
                     end
                     AddrMtvec: begin
                        mtvec_base_d = i_csr_wdata[31:2];
                        mtvec_mode_d = i_csr_wdata[0] & VECTORED_EN;
                     end
                     AddrMscratch: mscratch_d = i_csr_wdata;
                     AddrMepc:     mepc_d     = i_csr_wdata[31:2];
                     AddrMcause:   mcause_d   = i_csr_wdata;
                     AddrMtval:    mtval_d    = i_csr_wdata;
                     default: ;
                  endcase
               end
               if (i_mret) begin
                  mie_d   = mpie_q;
                  mpie_d  = 1'b1;
                  state_d = StRetRedir;
               end
            end
         end
         StTrapRedir: begin
            // Exceptions always target BASE, even in vectored mode.
            o_redirect    = 1'b1;
            o_redirect_pc = {mtvec_base_q, 2'b00};
            state_d       = StIdle;
         end
         StRetRedir: begin
            o_redirect    = 1'b1;
            o_redirect_pc = {mepc_q, 2'b00};
            state_d       = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      o_csr_hit   = 1'b1;
      o_csr_rdata = 32'h0;
      case (i_csr_addr)
         AddrMstatus:  o_csr_rdata = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
         AddrMtvec:    o_csr_rdata = {mtvec_base_q, 1'b0, mtvec_mode_q};
         AddrMscratch: o_csr_rdata = mscratch_q;
         AddrMepc:     o_csr_rdata = {mepc_q, 2'b00};
         AddrMcause:   o_csr_rdata = mcause_q;
         AddrMtval:    o_csr_rdata = mtval_q;
         default:      o_csr_hit   = 1'b0;
      endcase
   end

   assign o_busy = (state_q != StIdle) | i_trap_req | i_mret;
   assign o_mie  = mie_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: directed scenarios plus randomized traffic
// compared against a transaction-level model of the trap CSRs and redirects.
module tb_trap_sequencer;

   logic        clk, rst_n;
   logic        trap_req, mret, csr_we;
   logic [4:0]  trap_cause;
   logic [31:0] trap_tval, pc, csr_wdata;
   logic [11:0] csr_addr;

   logic [31:0] rdata_v, rdata_nv, rpc_v, rpc_nv;
   logic        hit_v, hit_nv, busy_v, busy_nv, redir_v, redir_nv, mie_v, mie_nv;

   trap_sequencer #(.MTVEC_RESET(32'h0), .VECTORED_EN(1'b1)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_trap_req(trap_req), .i_trap_cause(trap_cause),
      .i_trap_tval(trap_tval), .i_pc(pc), .i_mret(mret), .i_csr_we(csr_we),
      .i_csr_addr(csr_addr), .i_csr_wdata(csr_wdata), .o_csr_rdata(rdata_v),
      .o_csr_hit(hit_v), .o_busy(busy_v), .o_redirect(redir_v), .o_redirect_pc(rpc_v),
      .o_mie(mie_v)
   );

   trap_sequencer #(.MTVEC_RESET(32'h0), .VECTORED_EN(1'b0)) dut_nv (
      .i_clk(clk), .i_rst_n(rst_n), .i_trap_req(trap_req), .i_trap_cause(trap_cause),
      .i_trap_tval(trap_tval), .i_pc(pc), .i_mret(mret), .i_csr_we(csr_we),
      .i_csr_addr(csr_addr), .i_csr_wdata(csr_wdata), .o_csr_rdata(rdata_nv),
      .o_csr_hit(hit_nv), .o_busy(busy_nv), .o_redirect(redir_nv), .o_redirect_pc(rpc_nv),
      .o_mie(mie_nv)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state (raw values; architectural masking applied on read)
   bit          m_mie, m_mpie, exp_pend;
   logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, exp_pc;

   logic [31:0] obs_rdata, obs_rdata_nv, obs_pc;
   logic        obs_redir, obs_busy, obs_hit;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic void model_reset();
      m_mie = 0; m_mpie = 0; exp_pend = 0; exp_pc = 0;
      m_mtvec = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
   endfunction

   function automatic logic [31:0] model_read(input logic [11:0] a, input bit vect);
      case (a)
         12'h300: return 32'h1800 | (32'(m_mie) << 3) | (32'(m_mpie) << 7);
         12'h305: return vect ? (m_mtvec & 32'hFFFF_FFFD) : (m_mtvec & 32'hFFFF_FFFC);
         12'h340: return m_mscratch;
         12'h341: return m_mepc & 32'hFFFF_FFFC;
         12'h342: return m_mcause;
         12'h343: return m_mtval;
         default: return 32'h0;
      endcase
   endfunction

   function automatic bit model_hit(input logic [11:0] a);
      return a inside {12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343};
   endfunction

   // One clock cycle: drive at negedge, check combinational outputs, then advance the model.
   task automatic cycle(input bit req, input logic [4:0] c, input logic [31:0] tv,
                        input logic [31:0] p, input bit mr, input bit w,
                        input logic [11:0] a, input logic [31:0] wd);
      @(negedge clk);
      trap_req = req; trap_cause = c; trap_tval = tv; pc = p; mret = mr;
      csr_we = w; csr_addr = a; csr_wdata = wd;
      #1;
      obs_redir = redir_v; obs_pc = rpc_v; obs_busy = busy_v; obs_hit = hit_v;
      obs_rdata = rdata_v; obs_rdata_nv = rdata_nv;
      check_eq("redirect", {31'b0, redir_v}, {31'b0, exp_pend});
      check_eq("redirect_nv", {31'b0, redir_nv}, {31'b0, exp_pend});
      if (exp_pend) begin
         check_eq("redirect_pc", rpc_v, exp_pc);
         check_eq("redirect_pc_nv", rpc_nv, exp_pc);
      end
      check_eq("busy", {31'b0, busy_v}, {31'b0, exp_pend | req | mr});
      check_eq("hit", {31'b0, hit_v}, {31'b0, model_hit(a)});
      check_eq("rdata", rdata_v, model_read(a, 1'b1));
      check_eq("rdata_nv", rdata_nv, model_read(a, 1'b0));
      check_eq("mie", {31'b0, mie_v}, {31'b0, m_mie});

      if (exp_pend) begin
         exp_pend = 0;
      end else if (req) begin
         m_mepc = p; m_mcause = {27'b0, c}; m_mtval = tv;
         m_mpie = m_mie; m_mie = 0;
         exp_pend = 1; exp_pc = m_mtvec & 32'hFFFF_FFFC;
      end else begin
         if (w) begin
            case (a)
               12'h300: if (!mr) begin m_mie = wd[3]; m_mpie = wd[7]; end
               12'h305: m_mtvec = wd;
               12'h340: m_mscratch = wd;
               12'h341: m_mepc = wd;
               12'h342: m_mcause = wd;
               12'h343: m_mtval = wd;
               default: ;
            endcase
         end
         if (mr) begin
            m_mie = m_mpie; m_mpie = 1;
            exp_pend = 1; exp_pc = m_mepc & 32'hFFFF_FFFC;
         end
      end
   endtask

   task automatic idle(input logic [11:0] a);
      cycle(0, 5'd0, 32'h0, 32'h0, 0, 0, a, 32'h0);
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      cycle(0, 5'd0, 32'h0, 32'h0, 0, 1, a, d);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [11:0] addr_tab [8];

   initial begin
      addr_tab = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h301, 12'h7C0};
      rst_n = 0; trap_req = 0; trap_cause = 0; trap_tval = 0; pc = 0; mret = 0;
      csr_we = 0; csr_addr = 0; csr_wdata = 0;
      model_reset();
      @(negedge clk); #1;
      check_eq("rst_redirect", {31'b0, redir_v}, 32'h0);
      check_eq("rst_redirect_pc", rpc_v, 32'h0);
      check_eq("rst_busy", {31'b0, busy_v}, 32'h0);
      @(negedge clk); rst_n = 1;

      // Reset values
      idle(12'h305); check_eq("t1_mtvec", obs_rdata, 32'h0);
      idle(12'h300); check_eq("t1_mstatus", obs_rdata, 32'h0000_1800);

      // Trap entry
      wr(12'h305, 32'h0000_0101);
      wr(12'h300, 32'h0000_0008);
      cycle(1, 5'd2, 32'hFFFF_FFFF, 32'h40, 0, 0, 12'h300, 32'h0);
      check_eq("t2_busy_req", {31'b0, obs_busy}, 32'h1);
      idle(12'h341);
      check_eq("t2_redirect", {31'b0, obs_redir}, 32'h1);
      check_eq("t2_redirect_pc", obs_pc, 32'h100);
      check_eq("t2_mepc", obs_rdata, 32'h40);
      idle(12'h342); check_eq("t2_mcause", obs_rdata, 32'h2);
      idle(12'h343); check_eq("t2_mtval", obs_rdata, 32'hFFFF_FFFF);
      idle(12'h300); check_eq("t2_mstatus", obs_rdata, 32'h1880);

      // MRET return
      cycle(0, 5'd0, 32'h0, 32'h0, 1, 0, 12'h300, 32'h0);
      check_eq("t3_busy0", {31'b0, obs_busy}, 32'h1);
      idle(12'h300);
      check_eq("t3_busy1", {31'b0, obs_busy}, 32'h1);
      check_eq("t3_redirect_pc", obs_pc, 32'h40);
      check_eq("t3_mstatus", obs_rdata, 32'h1888);
      idle(12'h300);
      check_eq("t3_busy2", {31'b0, obs_busy}, 32'h0);

      // Trap beats MRET and a same-cycle CSR write
      cycle(1, 5'd11, 32'h0, 32'h80, 1, 1, 12'h340, 32'hDEAD_BEEF);
      idle(12'h342);
      check_eq("t4_redirect_pc", obs_pc, 32'h100);
      check_eq("t4_mcause", obs_rdata, 32'd11);
      idle(12'h341);
      check_eq("t4_no_ret", {31'b0, obs_redir}, 32'h0);
      check_eq("t4_mepc", obs_rdata, 32'h80);
      idle(12'h340); check_eq("t4_mscratch", obs_rdata, 32'h0);

      // Masking
      wr(12'h341, 32'h0000_1237);
      idle(12'h341); check_eq("t5_mepc", obs_rdata, 32'h1234);
      wr(12'h305, 32'h0000_0201);
      idle(12'h305);
      check_eq("t5_mtvec_vec", obs_rdata, 32'h201);
      check_eq("t5_mtvec_novec", obs_rdata_nv, 32'h200);

      // Randomized traffic, including requests during redirect cycles
      for (int i = 0; i < 500; i++) begin
         cycle($urandom_range(0, 5) == 0, 5'($urandom), $urandom, $urandom,
               $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
               addr_tab[$urandom_range(0, 7)], $urandom);
      end
      idle(12'h300);
      idle(12'h300);

      // Asynchronous reset during a trap redirect
      cycle(1, 5'd5, 32'h77, 32'h44, 0, 0, 12'h300, 32'h0);
      @(negedge clk);
      trap_req = 0; mret = 0; csr_we = 0;
      #1;
      check_eq("t6_redirect_pre", {31'b0, redir_v}, 32'h1);
      rst_n = 0;
      #1;
      check_eq("t6_redirect_rst", {31'b0, redir_v}, 32'h0);
      check_eq("t6_busy_rst", {31'b0, busy_v}, 32'h0);
      for (int k = 0; k < 6; k++) begin
         csr_addr = addr_tab[k];
         #1;
         check_eq("t6_csr_rst", rdata_v, (k == 0) ? 32'h1800 : 32'h0);
      end
      @(negedge clk); rst_n = 1;
      model_reset();
      idle(12'h300);
      check_eq("t6_busy_after", {31'b0, obs_busy}, 32'h0);
      idle(12'h305);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
